led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Memory-mapped sequencer that drives the write interface (we/wdata) of the 16-bit LED output register.
- The CPU programs mode, pattern and period over the data bus. The block then issues LED update writes autonomously:
  - static: written once
  - blink
  - rotate-left
  - rotate-right
- Sits between the bus decode and the LED register. While the sequencer is enabled, it is the only writer of that register.

Parameters:
- BASE_ADDR, 32'hFFFF_F100, byte base of the 3-word register window.
- CNT_W, 24, width of the period register and the frame counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- addr  in  32  CPU byte address.
- we  in  1  CPU write strobe, one cycle per write.
- wdata  in  32  CPU write data.
- led_we  out  1  write strobe to the LED register; one-cycle pulse per frame.
- led_wdata  out  16  frame value presented with led_we.
- busy  out  1  high while in any state other than S_IDLE.

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - +0x0 CTRL: bit0 = EN, bits[2:1] = MODE (0 static, 1 blink, 2 rotl, 3 rotr).
  - +0x4 PATTERN[15:0].
  - +0x8 PERIOD[CNT_W-1:0].
  - Other addresses are ignored. Upper wdata bits are ignored.
- Register writes take effect on the same clock edge as the we cycle.
- Reset values: CTRL=0, PATTERN=0, PERIOD=0, frame=0, counter=0, led_we=0, led_wdata=0, state=S_IDLE, busy=0.
- Effective period P = (PERIOD==0) ? 1 : PERIOD.
- States and transitions:
  - S_IDLE: no writes. Leaves on a CPU write that sets EN=1 → S_LOAD.
  - S_LOAD: frame ← PATTERN; counter ← 0.
    - Drives led_we=1 and led_wdata=PATTERN registered for the next cycle.
    - MODE==0 → S_HOLD; otherwise → S_WAIT.
  - S_WAIT: counter increments each cycle. When counter == P-1 → S_STEP.
  - S_STEP: compute the next frame and issue one led_we pulse with it, then → S_WAIT with counter=0.
    - blink: frame ^= PATTERN.
    - rotl: {frame[14:0], frame[15]}.
    - rotr: {frame[0], frame[15:1]}.
  - S_HOLD: no writes, waits for a register write.
  - S_CLEAR: one led_we pulse with led_wdata=16'h0000, then → S_IDLE.
- Write-to-LED latency:
  - CPU write setting EN at edge N → led_we high in cycle N+1 with PATTERN.
  - First step pulse at cycle N+1+P+1.
  - Step pulses then occur every P+1 cycles (P WAIT cycles + 1 STEP cycle).
- Any CPU write to CTRL/PATTERN/PERIOD while EN=1 (after that write) and state ≠ S_IDLE: → S_LOAD next cycle, restarting the sequence. A restart during S_STEP suppresses that step's pulse.
- A CPU write that clears EN from any non-idle state → S_CLEAR. A write clearing EN in S_IDLE does nothing.
- Blink with PATTERN=0 produces pulses of 0x0000. Rotate of 0x0000 or 0xFFFF produces pulses of unchanged value.
- Counter never exceeds P-1. A PERIOD write lowering P below the current count is harmless because it forces a restart.
- rst asserted mid-sequence: everything returns to reset values at that edge. No S_CLEAR pulse is issued, and led_we=0 during and after reset.
- led_we is never high for two consecutive cycles except an S_LOAD pulse immediately followed by P=1 behaviour (STEP requires ≥1 WAIT cycle, so this cannot occur).

Optional Feature:
- Macro: LED_SEQ_READBACK_EN.
- When defined:
  - Extra port rdata out 32, combinational read of the window.
  - +0x0 returns {28'b0, busy, MODE, EN}.
  - +0x4 returns {16'b0, PATTERN}.
  - +0x8 returns zero-extended PERIOD.
  - +0xC returns {16'b0, frame}.
  - Other addresses return 0.
- When undefined: no rdata port; no read mux logic.

Test Plan:
- Reset then idle 20 cycles → led_we never high, busy=0, led_wdata=0x0000.
- PATTERN=0x00F0, CTRL=0x1 (static) → exactly one led_we with 0x00F0 one cycle after the CTRL write, busy stays 1 (S_HOLD), no further pulses over 100 cycles.
- PATTERN=0x0001, PERIOD=3, CTRL=0x5 (rotl, EN) → pulses 0x0001, 0x0002, 0x0004, 0x0008 spaced 4 cycles apart. Repeat with rotr from 0x0001 → 0x8000 on the first step.
- Blink, PATTERN=0xAAAA, PERIOD=0 → pulses 0xAAAA, 0x0000, 0xAAAA spaced 2 cycles apart.
- Rotating with PERIOD=5, write CTRL=0x0 mid-WAIT → one led_we with 0x0000 next cycle, then S_IDLE, busy=0. Write PATTERN mid-WAIT → restart with the new pattern pulse next cycle.
- Assert rst for 1 cycle during S_WAIT in blink mode → led_we=0, led_wdata=0, busy=0 at the next cycle. No clear pulse; registers read back 0 under LED_SEQ_READBACK_EN.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - memory-mapped sequencer driving the 16-bit LED register write port
// Optional LED_SEQ_READBACK_EN adds a combinational rdata read port for the register window.
module led_seq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
   parameter int          CNT_W     = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic        led_we,
   output logic [15:0] led_wdata,
   output logic        busy
`ifdef LED_SEQ_READBACK_EN
   ,
   output logic [31:0] rdata
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STEP,
      S_HOLD,
      S_CLEAR
   } state_t;

   state_t           state, state_d;
   logic             en;
   logic [1:0]       mode;
   logic [15:0]      pattern;
   logic [CNT_W-1:0] period;
   logic [15:0]      frame, frame_d, next_frame;
   logic [CNT_W-1:0] cnt, cnt_d, pm1;
   logic             led_we_d;
   logic [15:0]      led_wdata_d;
   logic             wr_ctrl, wr_pat, wr_per, wr_any, en_new;
   logic             unused_wdata;

   assign wr_ctrl = we && (addr == BASE_ADDR);
   assign wr_pat  = we && (addr == BASE_ADDR + 32'd4);
   assign wr_per  = we && (addr == BASE_ADDR + 32'd8);
   assign wr_any  = wr_ctrl || wr_pat || wr_per;
   assign en_new  = wr_ctrl ? wdata[0] : en;
   assign pm1     = (period == '0) ? '0 : period - CNT_W'(1);
   assign busy    = (state != S_IDLE);
   assign unused_wdata = &{1'b0, wdata};

   always_comb begin
      next_frame = frame;
      case (mode)
         2'd1:    next_frame = frame ^ pattern;
         2'd2:    next_frame = {frame[14:0], frame[15]};
         2'd3:    next_frame = {frame[0], frame[15:1]};
         default: next_frame = frame;
      endcase
   end

   // Register writes pre-empt the running state, so a restart or clear swallows any pending pulse.
   always_comb begin
      state_d     = state;
      frame_d     = frame;
      cnt_d       = cnt;
      led_we_d    = 1'b0;
      led_wdata_d = led_wdata;
      if (wr_ctrl && !wdata[0] && state != S_IDLE) begin
         state_d = S_CLEAR;
      end else if (wr_any && en_new) begin
         state_d = S_LOAD;
      end else begin
         case (state)
            S_LOAD: begin
               frame_d     = pattern;
               cnt_d       = '0;
               led_we_d    = 1'b1;
               led_wdata_d = pattern;
               state_d     = (mode == 2'd0) ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
               if (cnt == pm1) state_d = S_STEP;
               else            cnt_d   = cnt + CNT_W'(1);
            end
            S_STEP: begin
               frame_d     = next_frame;
               led_we_d    = 1'b1;
               led_wdata_d = next_frame;
               cnt_d       = '0;
               state_d     = S_WAIT;
            end
            S_CLEAR: begin
               led_we_d    = 1'b1;
               led_wdata_d = 16'h0000;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         en        <= 1'b0;
         mode      <= 2'd0;
         pattern   <= 16'h0000;
         period    <= '0;
         frame     <= 16'h0000;
         cnt       <= '0;
         led_we    <= 1'b0;
         led_wdata <= 16'h0000;
      end else begin
         if (wr_ctrl) begin
            en   <= wdata[0];
            mode <= wdata[2:1];
         end
         if (wr_pat) pattern <= wdata[15:0];
         if (wr_per) period  <= wdata[CNT_W-1:0];
         state     <= state_d;
         frame     <= frame_d;
         cnt       <= cnt_d;
         led_we    <= led_we_d;
         led_wdata <= led_wdata_d;
      end
   end

`ifdef LED_SEQ_READBACK_EN
   always_comb begin
      rdata = 32'h0;
      if      (addr == BASE_ADDR)          rdata = {28'b0, busy, mode, en};
      else if (addr == BASE_ADDR + 32'd4)  rdata = {16'b0, pattern};
      else if (addr == BASE_ADDR + 32'd8)  rdata = 32'(period);
      else if (addr == BASE_ADDR + 32'd12) rdata = {16'b0, frame};
   end
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed table-driven bench for led_seq_ctrl
module tb_led_seq_ctrl;

   localparam logic [31:0] CTRL = 32'hFFFF_F100;
   localparam logic [31:0] PAT  = 32'hFFFF_F104;
   localparam logic [31:0] PER  = 32'hFFFF_F108;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        led_we;
   logic [15:0] led_wdata;
   logic        busy;
`ifdef LED_SEQ_READBACK_EN
   logic [31:0] rdata;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .we        (we),
      .wdata     (wdata),
      .led_we    (led_we),
      .led_wdata (led_wdata),
      .busy      (busy)
`ifdef LED_SEQ_READBACK_EN
      ,
      .rdata     (rdata)
`endif
   );

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        ew;
      logic [15:0] ewd;
      logic        eb;
   } vec_t;

   vec_t tbl[$];

   task automatic push(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic ew, input logic [15:0] ewd, input logic eb);
      vec_t v;
      v.r = r; v.w = w; v.a = a; v.d = d; v.ew = ew; v.ewd = ewd; v.eb = eb;
      tbl.push_back(v);
   endtask

   task automatic idle(input int n, input logic [15:0] ewd, input logic eb);
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ewd, eb);
   endtask

   // Program, run four pulses (P wait rows after each), then clear from S_STEP.
   task automatic seq(input logic [15:0] pat, input logic [31:0] per, input logic [31:0] ctrl,
                      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] e3, input int p);
      logic [15:0] ev[4];
      ev = '{e0, e1, e2, e3};
      push(1'b0, 1'b1, PAT, {16'h0, pat}, 1'b0, 16'h0, 1'b0);
      push(1'b0, 1'b1, PER, per, 1'b0, 16'h0, 1'b0);
      push(1'b0, 1'b1, CTRL, ctrl, 1'b0, 16'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, ev[k], 1'b1);
         idle(p, ev[k], 1'b1);
      end
      push(1'b0, 1'b1, CTRL, 32'h0, 1'b0, ev[3], 1'b1);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'h0000, 1'b0);
      idle(1, 16'h0000, 1'b0);
   endtask

   task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      rst = r; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s idx %0d got %h exp %h", name, idx, got, exp);
      end
   endtask

   initial begin
      push(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0);
      push(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0);
      idle(20, 16'h0000, 1'b0);
      push(1'b0, 1'b1, PAT, 32'h0000_00F0, 1'b0, 16'h0000, 1'b0);
      push(1'b0, 1'b1, CTRL, 32'h1, 1'b0, 16'h0000, 1'b1);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'h00F0, 1'b1);
      idle(100, 16'h00F0, 1'b1);
      push(1'b0, 1'b1, CTRL, 32'h0, 1'b0, 16'h00F0, 1'b1);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 16'h0000, 1'b0);
      idle(1, 16'h0000, 1'b0);
      seq(16'h0001, 32'd3, 32'h5, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 3);
      seq(16'h0001, 32'd3, 32'h7, 16'h0001, 16'h8000, 16'h4000, 16'h2000, 3);
      seq(16'hAAAA, 32'd0, 32'h3, 16'hAAAA, 16'h0000, 16'hAAAA, 16'h0000, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
         chk("tbl_led_we", i, {31'h0, led_we}, {31'h0, tbl[i].ew});
         chk("tbl_led_wdata", i, {16'h0, led_wdata}, {16'h0, tbl[i].ewd});
         chk("tbl_busy", i, {31'h0, busy}, {31'h0, tbl[i].eb});
      end

      // Pattern write mid-WAIT restarts with the new pattern
      cyc(1'b0, 1'b1, PAT, 32'h0003);
      cyc(1'b0, 1'b1, PER, 32'd5);
      cyc(1'b0, 1'b1, CTRL, 32'h5);
      chk("rs_busy", 0, {31'h0, busy}, 32'h1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("rs_load_we", 0, {31'h0, led_we}, 32'h1);
      chk("rs_load_wd", 0, {16'h0, led_wdata}, 32'h0003);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, PAT, 32'hFFFF_0100);
      chk("rs_wr_we", 0, {31'h0, led_we}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("rs_new_we", 0, {31'h0, led_we}, 32'h1);
      chk("rs_new_wd", 0, {16'h0, led_wdata}, 32'h0100);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 32'h0);
         chk("rs_wait_we", i, {31'h0, led_we}, 32'h0);
      end
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("rs_step_we", 0, {31'h0, led_we}, 32'h1);
      chk("rs_step_wd", 0, {16'h0, led_wdata}, 32'h0200);

      // Restart landing on S_STEP drops that step's pulse
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b1, PER, 32'd5);
      chk("sup_we", 0, {31'h0, led_we}, 32'h0);
      chk("sup_wd", 0, {16'h0, led_wdata}, 32'h0200);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("sup_load_we", 0, {31'h0, led_we}, 32'h1);
      chk("sup_load_wd", 0, {16'h0, led_wdata}, 32'h0100);

      // Reset during blink WAIT: no clear pulse, everything back to zero
      cyc(1'b0, 1'b1, CTRL, 32'h3);
      chk("bl_wr_we", 0, {31'h0, led_we}, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk("bl_load_wd", 0, {16'h0, led_wdata}, 32'h0100);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0, 32'h0);
      chk("rst_we", 0, {31'h0, led_we}, 32'h0);
      chk("rst_wd", 0, {16'h0, led_wdata}, 32'h0);
      chk("rst_busy", 0, {31'h0, busy}, 32'h0);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b0, CTRL + 32'(4 * (i % 4)), 32'h0);
         chk("post_rst_we", i, {31'h0, led_we}, 32'h0);
         chk("post_rst_busy", i, {31'h0, busy}, 32'h0);
`ifdef LED_SEQ_READBACK_EN
         chk("post_rst_rdata", i, rdata, 32'h0);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
